// File: rtl/datapath_unit.sv
// ---------------------------------------------------------------------------
// datapath_unit
// Execution datapath for the processor: a 16x16 register file, a 256x16
// synchronous data memory, a 16-bit ALU and the write-back select mux.
// The control unit drives every control input on a per-state basis.
//
// Parameters:
//   MEM_INIT_FILE  optional data-memory image name ("" = none); contents
//                  stay undefined until written
//
// Ports:
//   Clk         in   system clock, all state updates on the rising edge
//   Reset       in   synchronous active-high reset
//   D_Addr      in   [7:0]  data memory address
//   D_Wr        in   data memory write strobe (data = ALU_A)
//   RF_s        in   write-back select: 1 = Mem_Out, 0 = ALU_Out
//   RF_W_Addr   in   [3:0]  register-file write address
//   RF_W_en     in   register-file write enable
//   RF_Ra_Addr  in   [3:0]  read port A address
//   RF_Rb_Addr  in   [3:0]  read port B address
//   ALU_s0      in   [2:0]  ALU operation select
//   ALU_A       out  [15:0] port A data (ALU operand A, STORE data)
//   ALU_B       out  [15:0] port B data (ALU operand B)
//   ALU_Out     out  [15:0] ALU result
//   Mem_Out     out  [15:0] registered memory read data
//   RF_W_Data   out  [15:0] selected write-back value
//
// Optional feature (macro DATAPATH_FLAGS_EN):
//   Flag_Z, Flag_N, Flag_C, Flag_V  registered ALU status flags, updated
//   only on edges that write an ALU result into the register file.
// ---------------------------------------------------------------------------
module datapath_unit #(
    parameter string MEM_INIT_FILE = ""
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  D_Addr,
    input  logic        D_Wr,
    input  logic        RF_s,
    input  logic [3:0]  RF_W_Addr,
    input  logic        RF_W_en,
    input  logic [3:0]  RF_Ra_Addr,
    input  logic [3:0]  RF_Rb_Addr,
    input  logic [2:0]  ALU_s0,
    output logic [15:0] ALU_A,
    output logic [15:0] ALU_B,
    output logic [15:0] ALU_Out,
    output logic [15:0] Mem_Out,
    output logic [15:0] RF_W_Data
`ifdef DATAPATH_FLAGS_EN
    ,
    output logic        Flag_Z,
    output logic        Flag_N,
    output logic        Flag_C,
    output logic        Flag_V
`endif
);

    logic [15:0] rf_q [16];
    logic [15:0] mem_q [256];
    logic [15:0] mem_out_q;
    logic [15:0] alu_out_s;
    logic [15:0] rf_w_data_s;

    // No write bypass: reads always see the pre-edge register contents.
    assign ALU_A       = rf_q[RF_Ra_Addr];
    assign ALU_B       = rf_q[RF_Rb_Addr];
    assign rf_w_data_s = RF_s ? mem_out_q : alu_out_s;
    assign ALU_Out     = alu_out_s;
    assign Mem_Out     = mem_out_q;
    assign RF_W_Data   = rf_w_data_s;

    // ALU: 16-bit modulo arithmetic, carry never reaches the result.
    always_comb begin
        alu_out_s = 16'h0000;
        case (ALU_s0)
            3'b000:  alu_out_s = ALU_A;
            3'b001:  alu_out_s = ALU_A + ALU_B;
            3'b010:  alu_out_s = ALU_A - ALU_B;
            3'b011:  alu_out_s = ALU_A & ALU_B;
            3'b100:  alu_out_s = ALU_A | ALU_B;
            3'b101:  alu_out_s = ALU_A ^ ALU_B;
            3'b110:  alu_out_s = ALU_A + 16'h0001;
            3'b111:  alu_out_s = ~ALU_A;
            default: alu_out_s = 16'h0000;
        endcase
    end

    // Register file write port; reset clears every entry and blocks the write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= 16'h0000;
            end
        end else if (RF_W_en) begin
            rf_q[RF_W_Addr] <= rf_w_data_s;
        end else begin
            rf_q[RF_W_Addr] <= rf_q[RF_W_Addr];
        end
    end

    // Memory array write; contents survive reset, but a write during reset is dropped.
    always_ff @(posedge Clk) begin
        if (!Reset && D_Wr) begin
            mem_q[D_Addr] <= ALU_A;
        end
    end

    // Read data register refreshes every edge with the pre-write contents.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mem_out_q <= 16'h0000;
        end else begin
            mem_out_q <= mem_q[D_Addr];
        end
    end

`ifdef DATAPATH_FLAGS_EN
    logic flag_c_s;
    logic flag_v_s;
    logic flag_z_q, flag_n_q, flag_c_q, flag_v_q;

    // Carry and overflow of the current ALU op; derived by comparison so no
    // extra adder is needed.  For SUB, C means "no borrow" (A >= B).
    always_comb begin
        flag_c_s = 1'b0;
        flag_v_s = 1'b0;
        case (ALU_s0)
            3'b001: begin
                flag_c_s = (alu_out_s < ALU_A);
                flag_v_s = (ALU_A[15] == ALU_B[15]) && (alu_out_s[15] != ALU_A[15]);
            end
            3'b010: begin
                flag_c_s = (ALU_A >= ALU_B);
                flag_v_s = (ALU_A[15] != ALU_B[15]) && (alu_out_s[15] != ALU_A[15]);
            end
            3'b110: begin
                flag_c_s = (ALU_A == 16'hFFFF);
                flag_v_s = !ALU_A[15] && alu_out_s[15];
            end
            default: begin
                flag_c_s = 1'b0;
                flag_v_s = 1'b0;
            end
        endcase
    end

    // Flags track only ALU results that are actually written back.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else if (RF_W_en && !RF_s) begin
            flag_z_q <= (alu_out_s == 16'h0000);
            flag_n_q <= alu_out_s[15];
            flag_c_q <= flag_c_s;
            flag_v_q <= flag_v_s;
        end else begin
            flag_z_q <= flag_z_q;
            flag_n_q <= flag_n_q;
            flag_c_q <= flag_c_q;
            flag_v_q <= flag_v_q;
        end
    end

    assign Flag_Z = flag_z_q;
    assign Flag_N = flag_n_q;
    assign Flag_C = flag_c_q;
    assign Flag_V = flag_v_q;
`endif

endmodule

// File: tb/tb_datapath_unit.sv
// ---------------------------------------------------------------------------
// tb_datapath_unit
// Directed plus randomized checks of datapath_unit against a behavioural
// model (register/memory arrays and arithmetic on plain integers).
// ---------------------------------------------------------------------------
module tb_datapath_unit;

    logic        Clk;
    logic        Reset;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        RF_s;
    logic [3:0]  RF_W_Addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_Addr;
    logic [3:0]  RF_Rb_Addr;
    logic [2:0]  ALU_s0;
    logic [15:0] ALU_A, ALU_B, ALU_Out, Mem_Out, RF_W_Data;
`ifdef DATAPATH_FLAGS_EN
    logic        Flag_Z, Flag_N, Flag_C, Flag_V;
`endif

    datapath_unit dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .RF_W_Addr  (RF_W_Addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_Addr (RF_Ra_Addr),
        .RF_Rb_Addr (RF_Rb_Addr),
        .ALU_s0     (ALU_s0),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALU_Out    (ALU_Out),
        .Mem_Out    (Mem_Out),
        .RF_W_Data  (RF_W_Data)
`ifdef DATAPATH_FLAGS_EN
        ,
        .Flag_Z     (Flag_Z),
        .Flag_N     (Flag_N),
        .Flag_C     (Flag_C),
        .Flag_V     (Flag_V)
`endif
    );

    // clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [15:0] rf_m [16];
    logic [15:0] mem_m [256];
    bit          mem_v [256];
    logic [15:0] mo_m;
    bit          mo_v;
    bit          fz_m, fn_m, fc_m, fv_m;
    bit          chk_en;

    // stimulus for the next cycle
    logic        t_rst, t_dwr, t_rfs, t_wen;
    logic [7:0]  t_dad;
    logic [3:0]  t_wa, t_ra, t_rb;
    logic [2:0]  t_op;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int unsigned r;
        case (op)
            3'd0:    r = a;
            3'd1:    r = (int'(a) + int'(b)) % 65536;
            3'd2:    r = (int'(a) - int'(b) + 65536) % 65536;
            3'd3:    r = a & b;
            3'd4:    r = a | b;
            3'd5:    r = a ^ b;
            3'd6:    r = (int'(a) + 1) % 65536;
            default: r = 65535 - int'(a);
        endcase
        return r[15:0];
    endfunction

    // status flags from integer arithmetic
    task automatic flag_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                            output bit z, output bit n, output bit c, output bit v);
        logic [15:0] r;
        int sa, sb, s;
        r  = alu_ref(op, a, b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        z  = (r == 16'h0000);
        n  = r[15];
        c  = 1'b0;
        v  = 1'b0;
        if (op == 3'd1) begin
            c = (int'(a) + int'(b)) > 65535;
            s = sa + sb;
            v = (s > 32767) || (s < -32768);
        end else if (op == 3'd2) begin
            c = int'(a) >= int'(b);
            s = sa - sb;
            v = (s > 32767) || (s < -32768);
        end else if (op == 3'd6) begin
            c = (a == 16'hFFFF);
            s = sa + 1;
            v = s > 32767;
        end
    endtask

    task automatic idle();
        t_rst = 1'b0; t_dwr = 1'b0; t_rfs = 1'b0; t_wen = 1'b0;
        t_dad = 8'h00; t_wa = 4'h0; t_ra = 4'h0; t_rb = 4'h0; t_op = 3'd0;
    endtask

    task automatic drive();
        Reset = t_rst; D_Addr = t_dad; D_Wr = t_dwr; RF_s = t_rfs;
        RF_W_Addr = t_wa; RF_W_en = t_wen; RF_Ra_Addr = t_ra; RF_Rb_Addr = t_rb; ALU_s0 = t_op;
    endtask

    task automatic peek();
        drive();
        #1;
    endtask

    // one clock cycle: drive, compare against the model, then advance the model
    task automatic step();
        logic [15:0] a, b, alu, wd, n_mo;
        bit          n_v, z, n, c, v;
        drive();
        #2;
        a   = rf_m[t_ra];
        b   = rf_m[t_rb];
        alu = alu_ref(t_op, a, b);
        wd  = t_rfs ? mo_m : alu;
        if (chk_en) begin
            chk("alu_a", ALU_A, a);
            chk("alu_b", ALU_B, b);
            chk("alu_out", ALU_Out, alu);
            if (!t_rfs || mo_v) chk("rf_w_data", RF_W_Data, wd);
            if (mo_v) chk("mem_out", Mem_Out, mo_m);
`ifdef DATAPATH_FLAGS_EN
            chk("flags", {12'd0, Flag_Z, Flag_N, Flag_C, Flag_V}, {12'd0, fz_m, fn_m, fc_m, fv_m});
`endif
        end
        @(posedge Clk);
        if (t_rst) begin
            for (int i = 0; i < 16; i++) rf_m[i] = 16'h0000;
            mo_m = 16'h0000; mo_v = 1'b1;
            fz_m = 1'b0; fn_m = 1'b0; fc_m = 1'b0; fv_m = 1'b0;
        end else begin
            n_mo = mem_m[t_dad];
            n_v  = mem_v[t_dad];
            if (t_dwr) begin
                mem_m[t_dad] = a;
                mem_v[t_dad] = 1'b1;
            end
            if (t_wen) rf_m[t_wa] = wd;
            if (t_wen && !t_rfs) begin
                flag_ref(t_op, a, b, z, n, c, v);
                fz_m = z; fn_m = n; fc_m = c; fv_m = v;
            end
            mo_m = n_mo;
            mo_v = n_v;
        end
        chk_en = 1'b1;
        #1;
    endtask

    // register write helper: Rdst = op(Ra, Rb)
    task automatic alu_wr(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] wa);
        idle();
        t_op = op; t_ra = ra; t_rb = rb; t_wa = wa; t_wen = 1'b1;
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_v[i] = 1'b0;
        mo_v   = 1'b0;
        chk_en = 1'b0;
        idle();

        // reset with a pending register write
        t_rst = 1'b1; t_wen = 1'b1; t_wa = 4'd3;
        step();
        idle();
        t_ra = 4'd3; t_op = 3'b111; t_rfs = 1'b1;
        peek();
        chk("rst_rf3", ALU_A, 16'h0000);
        chk("rst_memout", Mem_Out, 16'h0000);
        chk("rst_alu_not", ALU_Out, 16'hFFFF);
        chk("rst_wdata", RF_W_Data, 16'h0000);
        step();

        // R10 = 5, R11 = 3 via increments
        for (int i = 0; i < 5; i++) alu_wr(3'b110, 4'd10, 4'd0, 4'd10);
        for (int i = 0; i < 3; i++) alu_wr(3'b110, 4'd11, 4'd0, 4'd11);
        alu_wr(3'b001, 4'd10, 4'd11, 4'd12);
        alu_wr(3'b010, 4'd10, 4'd11, 4'd13);
        idle(); t_ra = 4'd12; t_rb = 4'd13;
        peek();
        chk("add_r12", ALU_A, 16'h0008);
        chk("sub_r13", ALU_B, 16'h0002);

        // STORE R12 at 0xBC, LOAD back into R1
        idle(); t_ra = 4'd12; t_dad = 8'hBC; t_dwr = 1'b1;
        step();
        idle(); t_dad = 8'hBC;
        step();
        chk("load_memout", Mem_Out, 16'h0008);
        idle(); t_rfs = 1'b1; t_wen = 1'b1; t_wa = 4'd1;
        step();
        idle(); t_ra = 4'd1;
        peek();
        chk("load_r1", ALU_A, 16'h0008);

        // same-cycle write/read of R4: no bypass
        idle(); t_op = 3'b110; t_ra = 4'd4; t_wa = 4'd4; t_wen = 1'b1;
        peek();
        chk("nobypass_old", ALU_A, 16'h0000);
        step();
        idle(); t_ra = 4'd4;
        peek();
        chk("nobypass_new", ALU_A, 16'h0001);

        // STORE R13 at 0xBC while reading it: read-before-write
        idle(); t_ra = 4'd13; t_dad = 8'hBC; t_dwr = 1'b1;
        step();
        chk("rbw_old", Mem_Out, 16'h0008);
        idle(); t_dad = 8'hBC;
        step();
        chk("rbw_new", Mem_Out, 16'h0002);

        // 0xFFFF + 1 wraps to zero
        alu_wr(3'b111, 4'd0, 4'd0, 4'd5);
        alu_wr(3'b110, 4'd0, 4'd0, 4'd6);
        idle(); t_op = 3'b001; t_ra = 4'd5; t_rb = 4'd6; t_wa = 4'd7; t_wen = 1'b1;
        peek();
        chk("wrap_add", ALU_Out, 16'h0000);
        step();
`ifdef DATAPATH_FLAGS_EN
        chk("wrap_flags_zcv", {13'd0, Flag_Z, Flag_C, Flag_V}, {13'd0, 1'b1, 1'b1, 1'b0});
`endif

        // 0x8000 - 1 = 0x7FFF with signed overflow
        alu_wr(3'b000, 4'd6, 4'd0, 4'd8);
        for (int i = 0; i < 15; i++) alu_wr(3'b001, 4'd8, 4'd8, 4'd8);
        idle(); t_op = 3'b010; t_ra = 4'd8; t_rb = 4'd6; t_wa = 4'd9; t_wen = 1'b1;
        peek();
        chk("sub_ovf", ALU_Out, 16'h7FFF);
        step();
`ifdef DATAPATH_FLAGS_EN
        chk("sub_ovf_v", {15'd0, Flag_V}, 16'h0001);
`endif

        // reset during LOAD cycle B
        idle(); t_ra = 4'd13; t_dad = 8'h20; t_dwr = 1'b1;
        step();
        idle(); t_dad = 8'h20;
        step();
        idle(); t_rst = 1'b1; t_rfs = 1'b1; t_wen = 1'b1; t_wa = 4'd9;
        step();
        idle(); t_ra = 4'd9; t_dad = 8'h20;
        peek();
        chk("rstload_r9", ALU_A, 16'h0000);
        chk("rstload_memout", Mem_Out, 16'h0000);
        step();
        chk("rstload_mem_kept", Mem_Out, 16'h0002);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            t_rst = ($urandom_range(0, 49) == 0);
            t_dad = 8'($urandom_range(0, 15)) | (($urandom_range(0, 7) == 0) ? 8'hF0 : 8'h00);
            t_dwr = ($urandom_range(0, 2) == 0);
            t_wen = ($urandom_range(0, 1) == 0);
            t_rfs = mo_v && ($urandom_range(0, 3) == 0);
            t_wa  = 4'($urandom_range(0, 15));
            t_ra  = 4'($urandom_range(0, 15));
            t_rb  = 4'($urandom_range(0, 15));
            t_op  = 3'($urandom_range(0, 7));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
